// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads,
// buffers responses in a FIFO and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [ADDR_W-1:0] tag_q     [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW-1:0]     tag_wr, tag_rd;
    logic [CW-1:0]     count, outstanding, discard;
    logic [CW:0]       in_use;
    logic              credit, resp, push, pop;

    // Credit covers both buffered words and words still in flight,
    // so a returning response always finds a free FIFO slot.
    assign in_use = {1'b0, outstanding} + {1'b0, count};
    assign credit = in_use < (CW+1)'(DEPTH);

    // A response with nothing outstanding cannot belong to us.
    assign resp = imem_rvalid & (outstanding != '0);
    assign push = resp & (discard == '0) & ~redirect;
    assign pop  = inst_valid & inst_ready & ~redirect;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;
    assign imem_addr  = pc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; redirect never changes state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fetch_en)  state_nxt = FETCH;
            FETCH:   if (!fetch_en) state_nxt = HOLD;
            HOLD:    if (fetch_en)  state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: issue one request per cycle while credit allows
    always_comb begin
        imem_req = (state == FETCH) & ~redirect & credit;
    end

    // PC, pointers and credit/discard counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(imem_req) - CW'(resp);
            if (imem_req) tag_wr <= tag_wr + 1'b1;
            if (resp)     tag_rd <= tag_rd + 1'b1;
            if (redirect) begin
                pc      <= redirect_pc;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                discard <= outstanding - CW'(resp);
            end else begin
                if (imem_req) pc <= pc + ADDR_W'(1);
                if (push)     wr_ptr <= wr_ptr + 1'b1;
                if (pop)      rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (resp && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

    // Storage: tag queue of in-flight PCs and the instruction FIFO
    always_ff @(posedge clk) begin
        if (imem_req) tag_q[tag_wr] <= pc;
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order
// instruction memory model and a decode-side consumer log.
module tb_fetch_unit;

    localparam int DW = 19;
    localparam int AW = 19;
    localparam logic [DW-1:0] KEY = 19'h15A5A;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 1;

    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] got_pc[$];
    logic [DW-1:0] got_data[$];

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model and consumer log, evaluated mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata = '0;
        end else begin
            if (imem_req) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + mem_lat);
                req_log.push_back(imem_addr);
            end
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata = mq_addr[0] ^ KEY;
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
            if (inst_valid && inst_ready && !redirect) begin
                got_pc.push_back(inst_pc);
                got_data.push_back(inst_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        req_log.delete();
        got_pc.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req got=%b exp=0", imem_req);
        end
        checks++;
        if (imem_addr !== '0) begin
            errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got=%b exp=0", inst_valid);
        end
        checks++;
        if (inst_data !== '0) begin
            errors++; $display("FAIL rst_data got=%h exp=0", inst_data);
        end
        checks++;
        if (inst_pc !== '0) begin
            errors++; $display("FAIL rst_pc got=%h exp=0", inst_pc);
        end
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat = 1;
        inst_ready = 1'b1;
        fetch_en = 1'b1;
        tick(20);
        checks++;
        if (req_log.size() != 19) begin
            errors++; $display("FAIL stream_nreq got=%0d exp=19", req_log.size());
        end
        for (int i = 0; i < 19 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== AW'(i)) begin
                errors++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, req_log[i], AW'(i));
            end
        end
        checks++;
        if (got_pc.size() != 17) begin
            errors++; $display("FAIL stream_ninst got=%0d exp=17", got_pc.size());
        end
        for (int i = 0; i < 17 && i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== AW'(i) || got_data[i] !== (AW'(i) ^ KEY)) begin
                errors++;
                $display("FAIL stream_inst[%0d] got=%h/%h exp=%h/%h",
                         i, got_pc[i], got_data[i], AW'(i), AW'(i) ^ KEY);
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat = 3;
        inst_ready = 1'b0;
        fetch_en = 1'b1;
        tick(15);
        checks++;
        if (req_log.size() != 4) begin
            errors++; $display("FAIL bp_nreq got=%0d exp=4", req_log.size());
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_req got=%b exp=0", imem_req);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== '0 || inst_data !== KEY) begin
            errors++;
            $display("FAIL bp_head got=%b/%h/%h exp=1/0/%h", inst_valid, inst_pc, inst_data, KEY);
        end
        tick(3);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== '0) begin
            errors++; $display("FAIL bp_hold got=%b/%h exp=1/0", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick(20);
        checks++;
        if (got_pc.size() < 6 || req_log.size() < 6) begin
            errors++;
            $display("FAIL bp_drain_n got=%0d/%0d exp>=6", got_pc.size(), req_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_pc[i] !== AW'(i) || req_log[i] !== AW'(i)) begin
                    errors++;
                    $display("FAIL bp_drain[%0d] got=%h/%h exp=%h", i, got_pc[i], req_log[i], AW'(i));
                end
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_redirect();
        int n;
        int idx;
        do_reset();
        mem_lat = 3;
        inst_ready = 1'b1;
        fetch_en = 1'b1;
        n = 0;
        while (req_log.size() < 3 && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++; $display("FAIL redir_wait got=%0d exp=3 requests", req_log.size());
        end
        redirect = 1'b1;
        redirect_pc = 19'h00100;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_req got=%b exp=0", imem_req);
        end
        tick(1);
        redirect = 1'b0;
        idx = req_log.size();
        tick(25);
        checks++;
        if (req_log.size() <= idx || req_log[idx] !== 19'h00100) begin
            errors++; $display("FAIL redir_addr got_n=%0d exp first=00100", req_log.size() - idx);
        end
        checks++;
        if (got_pc.size() < 4) begin
            errors++; $display("FAIL redir_ninst got=%0d exp>=4", got_pc.size());
        end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== 19'h00100 + AW'(i) || got_data[i] !== ((19'h00100 + AW'(i)) ^ KEY)) begin
                errors++;
                $display("FAIL redir_inst[%0d] got=%h exp=%h", i, got_pc[i], 19'h00100 + AW'(i));
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_redirect_same_cycle();
        int n0;
        do_reset();
        mem_lat = 1;
        inst_ready = 1'b1;
        fetch_en = 1'b1;
        tick(8);
        n0 = got_pc.size();
        checks++;
        if (inst_valid !== 1'b1 || imem_rvalid !== 1'b1 || n0 == 0) begin
            errors++;
            $display("FAIL same_pre got=%b/%b/%0d exp=1/1/>0", inst_valid, imem_rvalid, n0);
        end else begin
            checks++;
            if (got_pc[n0-1] !== AW'(n0 - 1)) begin
                errors++; $display("FAIL same_last got=%h exp=%h", got_pc[n0-1], AW'(n0 - 1));
            end
        end
        redirect = 1'b1;
        redirect_pc = 19'h2A000;
        tick(1);
        redirect = 1'b0;
        tick(12);
        checks++;
        if (got_pc.size() < n0 + 4) begin
            errors++; $display("FAIL same_ninst got=%0d exp>=%0d", got_pc.size(), n0 + 4);
        end
        for (int i = n0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== 19'h2A000 + AW'(i - n0)) begin
                errors++;
                $display("FAIL same_inst[%0d] got=%h exp=%h", i, got_pc[i], 19'h2A000 + AW'(i - n0));
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_wrap();
        int n0;
        logic [AW-1:0] exp_pc [4];
        exp_pc[0] = 19'h7FFFE;
        exp_pc[1] = 19'h7FFFF;
        exp_pc[2] = 19'h00000;
        exp_pc[3] = 19'h00001;
        do_reset();
        mem_lat = 1;
        inst_ready = 1'b1;
        fetch_en = 1'b1;
        tick(5);
        n0 = got_pc.size();
        redirect = 1'b1;
        redirect_pc = 19'h7FFFE;
        tick(1);
        redirect = 1'b0;
        tick(10);
        checks++;
        if (got_pc.size() < n0 + 4) begin
            errors++; $display("FAIL wrap_ninst got=%0d exp>=%0d", got_pc.size(), n0 + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_pc[n0+i] !== exp_pc[i] || got_data[n0+i] !== (exp_pc[i] ^ KEY)) begin
                    errors++;
                    $display("FAIL wrap_inst[%0d] got=%h/%h exp=%h/%h",
                             i, got_pc[n0+i], got_data[n0+i], exp_pc[i], exp_pc[i] ^ KEY);
                end
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        mem_lat = 3;
        inst_ready = 1'b1;
        fetch_en = 1'b1;
        n = 0;
        while (req_log.size() < 2 && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 50 || imem_addr !== 19'h00002) begin
            errors++; $display("FAIL mid_wait got=%0d/%h exp=2/00002", req_log.size(), imem_addr);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || inst_valid !== 1'b0
            || inst_data !== '0 || inst_pc !== '0) begin
            errors++;
            $display("FAIL mid_rst got=%b/%h/%b/%h/%h exp=all 0",
                     imem_req, imem_addr, inst_valid, inst_data, inst_pc);
        end
        fetch_en = 1'b0;
        tick(2);
        reset = 1'b1;
        req_log.delete();
        got_pc.delete();
        got_data.delete();
        tick(6);
        checks++;
        if (got_pc.size() != 0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle got=%0d/%b/%b exp=0/0/0", got_pc.size(), inst_valid, imem_req);
        end
        fetch_en = 1'b1;
        tick(8);
        checks++;
        if (req_log.size() == 0 || got_pc.size() == 0
            || req_log[0] !== '0 || got_pc[0] !== '0) begin
            errors++; $display("FAIL mid_restart got_n=%0d/%0d exp first pc 0",
                               req_log.size(), got_pc.size());
        end
        fetch_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
